// File: rtl/pi_step_scheduler.sv
// Time-step scheduler that multiplexes four channels onto one fixed-latency PI datapath.
// Channels are issued in ascending order. Each issued result is captured LAT cycles
// after its issue, then committed with a one-hot sta pulse.
// Optional macro PI_SCHED_CLAMP_EN: clamps captured results to +/-YLIM and flags sat.
module pi_step_scheduler #(
  parameter int unsigned LAT  = 14,
  parameter logic [31:0] YLIM = 32'h42C80000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_start,
  input  logic [3:0]   ch_en,
  input  logic [127:0] x_in,
  output logic [31:0]  pi_x,
  output logic [1:0]   pi_ch,
  output logic         pi_valid,
  input  logic [31:0]  pi_y,
  output logic [3:0]   sta,
  output logic [127:0] y_out,
  output logic         busy,
  output logic         done,
  output logic         overrun,
  output logic [3:0]   sat
);

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 6;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, CAPTURE, COMMIT, DONE
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [NCH-1:0]  pend;
  logic [NCH-1:0]  cand;
  logic [1:0]      nxt_ch;
  logic            nxt_any;
  logic            accept;
  logic [31:0]     cap_y;

  assign accept = (state == IDLE) && step_start;

  // Pick the lowest still-pending channel: the fresh mask when idle, else the remainder past the current one.
  always_comb begin
    cand    = (state == IDLE) ? ch_en : (pend & ~(4'b0001 << pi_ch));
    nxt_any = |cand;
    nxt_ch  = 2'd0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cand[i]) nxt_ch = 2'(i);
    end
  end

`ifdef PI_SCHED_CLAMP_EN
  logic cap_over;

  // Magnitude clamp on the raw bit pattern; NaN/Inf exponents exceed any finite limit.
  always_comb begin
    cap_over = pi_y[30:0] > YLIM[30:0];
    cap_y    = cap_over ? {pi_y[31], YLIM[30:0]} : pi_y;
  end

  // Sticky per-channel saturation flags, cleared when a step is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat <= 4'b0000;
    end else if (accept) begin
      sat <= 4'b0000;
    end else if (state == CAPTURE && cap_over) begin
      sat[pi_ch] <= 1'b1;
    end
  end
`else
  assign cap_y = pi_y;
  assign sat   = 4'b0000;
`endif

  // Next-state logic; the WAIT counter makes CAPTURE land exactly LAT cycles after ISSUE.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        if (step_start) state_d = nxt_any ? ISSUE : DONE;
      end
      ISSUE: begin
        if (LAT > 1) begin
          state_d = WAIT;
          cnt_d   = CW'(LAT - 2);
        end else begin
          state_d = CAPTURE;
        end
      end
      WAIT: begin
        if (cnt == '0) state_d = CAPTURE;
        else           cnt_d   = cnt - CW'(1);
      end
      CAPTURE: state_d = COMMIT;
      COMMIT:  state_d = nxt_any ? ISSUE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus registered outputs, all decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pend     <= '0;
      pi_x     <= '0;
      pi_ch    <= '0;
      pi_valid <= 1'b0;
      sta      <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
      y_out    <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      pi_valid <= (state_d == ISSUE);
      sta      <= (state_d == COMMIT) ? (4'b0001 << pi_ch) : 4'b0000;
      done     <= (state_d == DONE);
      busy     <= (state_d != IDLE);
      if (step_start && state != IDLE) overrun <= 1'b1;
      if (accept)               pend <= ch_en;
      else if (state == COMMIT) pend <= cand;
      if (state_d == ISSUE) begin
        pi_ch <= nxt_ch;
        pi_x  <= x_in[{nxt_ch, 5'd0} +: 32];
      end
      if (state == CAPTURE) y_out[{pi_ch, 5'd0} +: 32] <= cap_y;
    end
  end

endmodule

// File: tb/tb_pi_step_scheduler.sv
// Directed testbench for pi_step_scheduler (default LAT=14, YLIM=100.0).
// Cycle 0 is the cycle in which step_start is sampled; outputs are read #1 after each edge.
module tb_pi_step_scheduler;

  logic         clk = 1'b0;
  logic         rst;
  logic         step_start;
  logic [3:0]   ch_en;
  logic [127:0] x_in;
  logic [31:0]  pi_x;
  logic [1:0]   pi_ch;
  logic         pi_valid;
  logic [31:0]  pi_y;
  logic [3:0]   sta;
  logic [127:0] y_out;
  logic         busy;
  logic         done;
  logic         overrun;
  logic [3:0]   sat;

  int checks = 0;
  int errors = 0;

  // Per-run records filled by run_step.
  int          issue_n, sta_n, done_n, done_cyc, viol;
  int          issue_cyc [8];
  logic [1:0]  issue_ch  [8];
  logic [31:0] issue_x   [8];
  int          sta_cyc   [8];
  logic [3:0]  sta_val   [8];
  logic [127:0] snap_y;
  logic [42:0]  snap_o;

  logic [31:0] xs [4];

  pi_step_scheduler dut (
    .clk(clk), .rst(rst), .step_start(step_start), .ch_en(ch_en), .x_in(x_in),
    .pi_x(pi_x), .pi_ch(pi_ch), .pi_valid(pi_valid), .pi_y(pi_y), .sta(sta),
    .y_out(y_out), .busy(busy), .done(done), .overrun(overrun), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one step and record outputs for cycles 1..ncyc.
  task automatic run_step(input logic [3:0] mask, input int ncyc, input int restart_at,
                          input int rst_at, input logic [31:0] ybase, input bit yconst);
    issue_n = 0; sta_n = 0; done_n = 0; done_cyc = -1; viol = 0;
    snap_y = '1; snap_o = '1;
    ch_en = mask; step_start = 1'b1; pi_y = 32'h0;
    tick();
    step_start = 1'b0;
    ch_en = ~mask;
    for (int c = 1; c <= ncyc; c++) begin
      pi_y       = yconst ? ybase : ybase + 32'(c);
      step_start = (c == restart_at);
      rst        = (c == rst_at);
      if (pi_valid) begin
        if (issue_n < 8) begin
          issue_cyc[issue_n] = c; issue_ch[issue_n] = pi_ch; issue_x[issue_n] = pi_x;
        end
        issue_n++;
      end
      if (sta != 4'b0000) begin
        if (sta_n < 8) begin
          sta_cyc[sta_n] = c; sta_val[sta_n] = sta;
        end
        sta_n++;
      end
      if (done) begin
        if (done_cyc < 0) done_cyc = c;
        done_n++;
      end
      if ((pi_valid && sta != 4'b0000) || ($countones(sta) > 1) ||
          (!busy && (pi_valid || sta != 4'b0000 || done)))
        viol++;
      if (c == rst_at + 1) begin
        snap_y = y_out;
        snap_o = {pi_x, pi_ch, pi_valid, sta, busy, done, overrun, sat};
      end
      tick();
    end
    step_start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; step_start = 1'b1; ch_en = 4'hF;
    tick(); tick();
    checks++;
    if ({pi_x, pi_ch, pi_valid, sta, busy, done, overrun, sat} !== 43'h0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", {pi_x, pi_ch, pi_valid, sta, busy, done, overrun, sat});
    end
    checks++;
    if (y_out !== 128'h0) begin
      errors++; $display("FAIL reset_y_out got %h want 0", y_out);
    end
    step_start = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_no_latch busy got %b want 0", busy);
    end
  endtask

  task automatic test_single();
    run_step(4'b0001, 22, -1, -1, 32'h3F800000, 1'b0);
    checks++;
    if (issue_n !== 1 || issue_cyc[0] !== 1 || issue_ch[0] !== 2'd0 || issue_x[0] !== xs[0]) begin
      errors++; $display("FAIL single_issue got n=%0d cyc=%0d ch=%0d x=%h want n=1 cyc=1 ch=0 x=%h",
                         issue_n, issue_cyc[0], issue_ch[0], issue_x[0], xs[0]);
    end
    checks++;
    if (sta_n !== 1 || sta_cyc[0] !== 16 || sta_val[0] !== 4'b0001) begin
      errors++; $display("FAIL single_sta got n=%0d cyc=%0d val=%b want n=1 cyc=16 val=0001",
                         sta_n, sta_cyc[0], sta_val[0]);
    end
    checks++;
    if (done_cyc !== 17 || done_n !== 1) begin
      errors++; $display("FAIL single_done got cyc=%0d n=%0d want cyc=17 n=1", done_cyc, done_n);
    end
    checks++;
    if (y_out[31:0] !== 32'h3F80000F) begin
      errors++; $display("FAIL single_y got %h want 3f80000f", y_out[31:0]);
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL single_invariants got %0d want 0", viol);
    end
  endtask

  task automatic test_all_channels();
    run_step(4'b1111, 70, -1, -1, 32'h3F800000, 1'b0);
    checks++;
    if (issue_n !== 4 || issue_cyc[0] !== 1 || issue_cyc[1] !== 17 || issue_cyc[2] !== 33 || issue_cyc[3] !== 49) begin
      errors++; $display("FAIL all_issue_cycles got n=%0d %0d %0d %0d %0d want 4 1 17 33 49",
                         issue_n, issue_cyc[0], issue_cyc[1], issue_cyc[2], issue_cyc[3]);
    end
    checks++;
    if ({issue_ch[0], issue_ch[1], issue_ch[2], issue_ch[3]} !== 8'b00_01_10_11 ||
        issue_x[1] !== xs[1] || issue_x[2] !== xs[2] || issue_x[3] !== xs[3]) begin
      errors++; $display("FAIL all_issue_ch got ch=%0d%0d%0d%0d x3=%h want ch=0123 x3=%h",
                         issue_ch[0], issue_ch[1], issue_ch[2], issue_ch[3], issue_x[3], xs[3]);
    end
    checks++;
    if (sta_n !== 4 || {sta_val[0], sta_val[1], sta_val[2], sta_val[3]} !== 16'h1248 || sta_cyc[3] !== 64) begin
      errors++; $display("FAIL all_sta got n=%0d order=%h last=%0d want n=4 order=1248 last=64",
                         sta_n, {sta_val[0], sta_val[1], sta_val[2], sta_val[3]}, sta_cyc[3]);
    end
    checks++;
    if (done_cyc !== 65) begin
      errors++; $display("FAIL all_done got %0d want 65", done_cyc);
    end
    checks++;
    if (y_out !== 128'h3F80003F_3F80002F_3F80001F_3F80000F) begin
      errors++; $display("FAIL all_y got %h want 3f80003f3f80002f3f80001f3f80000f", y_out);
    end
    checks++;
    if (viol !== 0) begin
      errors++; $display("FAIL all_invariants got %0d want 0", viol);
    end
  endtask

  task automatic test_sparse();
    run_step(4'b1010, 40, -1, -1, 32'h3F800000, 1'b0);
    checks++;
    if (issue_n !== 2 || issue_cyc[0] !== 1 || issue_ch[0] !== 2'd1 || issue_cyc[1] !== 17 || issue_ch[1] !== 2'd3) begin
      errors++; $display("FAIL sparse_issue got n=%0d c0=%0d ch0=%0d c1=%0d ch1=%0d want 2 1 1 17 3",
                         issue_n, issue_cyc[0], issue_ch[0], issue_cyc[1], issue_ch[1]);
    end
    checks++;
    if (done_cyc !== 33) begin
      errors++; $display("FAIL sparse_done got %0d want 33", done_cyc);
    end
    checks++;
    if (y_out !== 128'h3F80001F_3F80002F_3F80000F_3F80000F) begin
      errors++; $display("FAIL sparse_y got %h want 3f80001f3f80002f3f80000f3f80000f", y_out);
    end
  endtask

  task automatic test_empty();
    run_step(4'b0000, 6, -1, -1, 32'h3F800000, 1'b0);
    checks++;
    if (done_cyc !== 1 || done_n !== 1 || issue_n !== 0 || sta_n !== 0) begin
      errors++; $display("FAIL empty got done=%0d n=%0d issues=%0d sta=%0d want 1 1 0 0",
                         done_cyc, done_n, issue_n, sta_n);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_clear got %b want 0", overrun);
    end
    run_step(4'b1111, 70, 5, -1, 32'h3F800000, 1'b0);
    checks++;
    if (overrun !== 1'b1 || done_cyc !== 65 || issue_n !== 4 || done_n !== 1) begin
      errors++; $display("FAIL overrun_busy got ovr=%b done=%0d issues=%0d want 1 65 4",
                         overrun, done_cyc, issue_n);
    end
  endtask

  task automatic test_done_coincident();
    rst = 1'b1; tick(); rst = 1'b0;
    run_step(4'b0001, 26, 17, -1, 32'h3F800000, 1'b0);
    checks++;
    if (overrun !== 1'b1 || issue_n !== 1 || done_n !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_coincident got ovr=%b issues=%0d dones=%0d busy=%b want 1 1 1 0",
                         overrun, issue_n, done_n, busy);
    end
  endtask

  task automatic test_mid_reset();
    run_step(4'b0001, 30, -1, 8, 32'h3F800000, 1'b0);
    checks++;
    if (snap_o !== 43'h0 || snap_y !== 128'h0) begin
      errors++; $display("FAIL mid_reset_outputs got %h y=%h want 0", snap_o, snap_y);
    end
    checks++;
    if (sta_n !== 0 || done_n !== 0 || issue_n !== 1) begin
      errors++; $display("FAIL mid_reset_after got sta=%0d done=%0d issues=%0d want 0 0 1",
                         sta_n, done_n, issue_n);
    end
    run_step(4'b0100, 22, -1, -1, 32'h3F800000, 1'b0);
    checks++;
    if (done_cyc !== 17 || issue_ch[0] !== 2'd2 || y_out !== 128'h00000000_3F80000F_00000000_00000000) begin
      errors++; $display("FAIL post_reset_step got done=%0d ch=%0d y=%h want 17 2 y2=3f80000f",
                         done_cyc, issue_ch[0], y_out);
    end
  endtask

  task automatic test_clamp();
`ifdef PI_SCHED_CLAMP_EN
    run_step(4'b0001, 20, -1, -1, 32'hC3480000, 1'b1);
    checks++;
    if (y_out[31:0] !== 32'hC2C80000 || sat !== 4'b0001) begin
      errors++; $display("FAIL clamp_neg got y=%h sat=%b want c2c80000 0001", y_out[31:0], sat);
    end
    run_step(4'b0001, 20, -1, -1, 32'h42480000, 1'b1);
    checks++;
    if (y_out[31:0] !== 32'h42480000 || sat !== 4'b0000) begin
      errors++; $display("FAIL clamp_pass got y=%h sat=%b want 42480000 0000", y_out[31:0], sat);
    end
    run_step(4'b1000, 20, -1, -1, 32'h7FC00000, 1'b1);
    checks++;
    if (y_out[127:96] !== 32'h42C80000 || sat !== 4'b1000) begin
      errors++; $display("FAIL clamp_nan got y=%h sat=%b want 42c80000 1000", y_out[127:96], sat);
    end
`else
    run_step(4'b0001, 20, -1, -1, 32'hC3480000, 1'b1);
    checks++;
    if (y_out[31:0] !== 32'hC3480000 || sat !== 4'b0000) begin
      errors++; $display("FAIL noclamp got y=%h sat=%b want c3480000 0000", y_out[31:0], sat);
    end
`endif
  endtask

  initial begin
    xs[0] = 32'h3F800000; xs[1] = 32'h40000000; xs[2] = 32'h40400000; xs[3] = 32'h40800000;
    x_in = {xs[3], xs[2], xs[1], xs[0]};
    rst = 1'b1; step_start = 1'b0; ch_en = 4'h0; pi_y = 32'h0;
    test_reset();
    test_single();
    test_all_channels();
    test_sparse();
    test_empty();
    test_overrun();
    test_done_coincident();
    test_mid_reset();
    test_clamp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
